approx_error_monitor: RTL and testbench

Streaming error-characterisation stage placed directly downstream of the 16-bit approximate Ladner-Fischer adder. Each sample carries the adder's operands, its carry-in and its 17-bit approximate sum. The block recomputes the exact sum for every sample and accumulates three metrics over a fixed window of 2^WIN_LOG2 samples: erroneous-result count, maximum error distance (ED) and sum of error distances (SED). It is the hardware back-end for the team's PPA-versus-accuracy sweeps.

---
 rtl/approx_eval_pkg.sv | 23 ++
 rtl/error_distance.sv | 24 ++
 rtl/approx_error_monitor.sv | 137 +++++++++++++
 tb/tb_approx_error_monitor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/approx_eval_pkg.sv
// Shared definitions for the approximate-adder error-characterisation blocks.
//   - state_t      : control states of the window monitor (IDLE, RUN, DRAIN)
//   - DEF_WIDTH    : default adder operand width
//   - DEF_WIN_LOG2 : default log2 of the window length in samples
//   - sed_width()  : width of a sum-of-error-distances accumulator that cannot overflow
package approx_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_WIN_LOG2 = 10;

  // A single ED is at most WIDTH+1 bits; summing 2^win_log2 of them needs
  // win_log2 extra bits.
  function automatic int sed_width(input int width, input int win_log2);
    return width + 1 + win_log2;
  endfunction

endpackage

// File: rtl/error_distance.sv
// Combinational unsigned error distance |i_exact - i_approx|.
// Ports:
//   i_exact  [W-1:0] reference (exact) value
//   i_approx [W-1:0] approximate value
//   o_ed     [W-1:0] absolute difference, valid for either ordering
module error_distance #(
  parameter int W = 17
) (
  input  logic [W-1:0] i_exact,
  input  logic [W-1:0] i_approx,
  output logic [W-1:0] o_ed
);

  // Subtract the smaller operand from the larger so the result never wraps.
  always_comb begin
    o_ed = '0;
    if (i_exact >= i_approx) begin
      o_ed = i_exact - i_approx;
    end else begin
      o_ed = i_approx - i_exact;
    end
  end

endmodule

// File: rtl/approx_error_monitor.sv
// Streaming error monitor for a WIDTH-bit approximate adder. For every accepted
// sample it recomputes the exact sum, takes the error distance against the
// approximate sum and accumulates, over a window of 2^WIN_LOG2 samples, the
// erroneous-result count, the maximum ED and the sum of EDs.
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_start               begin a new window (honoured only in IDLE)
//   i_in_valid/o_in_ready sample handshake; o_in_ready is high only in RUN
//   i_a, i_b, i_carry_in  adder operands and carry-in
//   i_approx_sum          approximate adder result, WIDTH+1 bits
//   o_busy                state != IDLE
//   o_done                one-cycle pulse when the window metrics are final
//   o_err_count           number of samples with ED != 0
//   o_max_ed              largest ED seen in the window
//   o_sed                 sum of all EDs in the window
module approx_error_monitor
  import approx_eval_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  parameter int SED_W    = sed_width(WIDTH, WIN_LOG2)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [WIDTH-1:0]    i_a,
  input  logic [WIDTH-1:0]    i_b,
  input  logic                i_carry_in,
  input  logic [WIDTH:0]      i_approx_sum,
  output logic                o_busy,
  output logic                o_done,
  output logic [WIN_LOG2:0]   o_err_count,
  output logic [WIDTH:0]      o_max_ed,
  output logic [SED_W-1:0]    o_sed
);

  state_t                r_state;
  logic [WIN_LOG2-1:0]   r_cnt;
  logic                  r_s1_valid;
  logic [WIDTH:0]        r_s1_exact;
  logic [WIDTH:0]        r_s1_approx;
  logic                  r_done;
  logic [WIN_LOG2:0]     r_err_count;
  logic [WIDTH:0]        r_max_ed;
  logic [SED_W-1:0]      r_sed;

  logic                  w_accept;
  logic                  w_last;
  logic [WIDTH:0]        w_exact;
  logic [WIDTH:0]        w_ed;
  logic                  w_ed_nz;

  assign w_accept = (r_state == ST_RUN) && i_in_valid;
  // Counter wraps to zero on the final sample; all-ones marks the last one.
  assign w_last   = &r_cnt;
  assign w_exact  = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_carry_in};
  assign w_ed_nz  = |w_ed;

  error_distance #(
    .W (WIDTH + 1)
  ) u_error_distance (
    .i_exact  (r_s1_exact),
    .i_approx (r_s1_approx),
    .o_ed     (w_ed)
  );

  // Control FSM, stage-1 capture and metric accumulation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_exact  <= '0;
      r_s1_approx <= '0;
      r_done      <= 1'b0;
      r_err_count <= '0;
      r_max_ed    <= '0;
      r_sed       <= '0;
    end else begin
      r_done     <= 1'b0;
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_exact  <= w_exact;
        r_s1_approx <= i_approx_sum;
      end

      // Stage 2: fold the retiring sample into the window metrics.
      if (r_s1_valid) begin
        r_sed       <= r_sed + {{(SED_W-WIDTH-1){1'b0}}, w_ed};
        r_err_count <= r_err_count + {{WIN_LOG2{1'b0}}, w_ed_nz};
        if (w_ed > r_max_ed) begin
          r_max_ed <= w_ed;
        end
      end

      case (r_state)
        ST_IDLE: begin
          // Stage 1 is never valid in IDLE, so this clear cannot race an update.
          if (i_start) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_err_count <= '0;
            r_max_ed    <= '0;
            r_sed       <= '0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_cnt <= r_cnt + {{(WIN_LOG2-1){1'b0}}, 1'b1};
            if (w_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // DRAIN is entered with the final sample in stage 1; it retires on
          // this edge, so the metrics are final from the next cycle.
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = (r_state == ST_RUN);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = r_done;
  assign o_err_count = r_err_count;
  assign o_max_ed    = r_max_ed;
  assign o_sed       = r_sed;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed self-checking bench for approx_error_monitor with a 4-sample window.
module tb_approx_error_monitor;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [16:0] approx;
  logic        busy;
  logic        done;
  logic [2:0]  err_count;
  logic [16:0] max_ed;
  logic [18:0] sed;

  int errors = 0;
  int checks = 0;

  approx_error_monitor #(
    .WIDTH    (16),
    .WIN_LOG2 (2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_a          (a),
    .i_b          (b),
    .i_carry_in   (cin),
    .i_approx_sum (approx),
    .o_busy       (busy),
    .o_done       (done),
    .o_err_count  (err_count),
    .o_max_ed     (max_ed),
    .o_sed        (sed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for one cycle; returns 1 unit after the edge that takes it.
  task automatic drive_sample(input logic [15:0] ta, input logic [15:0] tb,
                              input logic tc, input logic [16:0] tapx);
    a = ta; b = tb; cin = tc; approx = tapx;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Pulse Start for one edge.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    a = 16'h0; b = 16'h0; cin = 1'b0; approx = 17'h0;
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if ({err_count, max_ed, sed} !== 39'h0) begin errors++; $display("FAIL reset_metrics: got %h/%h/%h want 0", err_count, max_ed, sed); end
    tick(); tick();
    rst = 1'b0;
    // Samples offered without Start must be ignored.
    in_valid = 1'b1; a = 16'h0001; b = 16'h0001; approx = 17'h00007;
    tick(); tick(); tick();
    in_valid = 1'b0;
    checks++; if ({in_ready, busy, done} !== 3'b000) begin errors++; $display("FAIL idle_after_reset: got rdy/busy/done %b%b%b want 000", in_ready, busy, done); end
    checks++; if ({err_count, max_ed, sed} !== 39'h0) begin errors++; $display("FAIL idle_metrics: got %h/%h/%h want 0", err_count, max_ed, sed); end
  endtask

  task automatic test_exact_window();
    do_start();
    checks++; if ({in_ready, busy} !== 2'b11) begin errors++; $display("FAIL exact_start: got rdy/busy %b%b want 11", in_ready, busy); end
    drive_sample(16'h1234, 16'h4321, 1'b0, 17'h05555);
    drive_sample(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    drive_sample(16'h8000, 16'h8000, 1'b1, 17'h10001);
    drive_sample(16'h00FF, 16'h0F00, 1'b1, 17'h01000);
    // Final sample just accepted: DRAIN, ready low, still busy.
    checks++; if ({in_ready, busy, done} !== 3'b010) begin errors++; $display("FAIL exact_drain: got rdy/busy/done %b%b%b want 010", in_ready, busy, done); end
    tick();
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL exact_done: got busy/done %b%b want 01", busy, done); end
    checks++; if ({err_count, max_ed, sed} !== 39'h0) begin errors++; $display("FAIL exact_metrics: got %h/%h/%h want 0", err_count, max_ed, sed); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL exact_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_mixed_errors();
    do_start();
    drive_sample(16'h003F, 16'h0001, 1'b0, 17'h0003C);
    tick();
    // First sample visible one edge after acceptance.
    checks++; if (sed !== 19'h00004) begin errors++; $display("FAIL mixed_live_sed: got %h want 00004", sed); end
    checks++; if (err_count !== 3'd1) begin errors++; $display("FAIL mixed_live_cnt: got %0d want 1", err_count); end
    drive_sample(16'hFFFF, 16'hFFFF, 1'b1, 17'h00000);
    drive_sample(16'h0000, 16'h0000, 1'b0, 17'h00005);
    drive_sample(16'h0100, 16'h0200, 1'b1, 17'h00301);
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mixed_done: got %b want 1", done); end
    checks++; if (err_count !== 3'd3) begin errors++; $display("FAIL mixed_err_count: got %0d want 3", err_count); end
    checks++; if (max_ed !== 17'h1FFFF) begin errors++; $display("FAIL mixed_max_ed: got %h want 1ffff", max_ed); end
    checks++; if (sed !== 19'h20008) begin errors++; $display("FAIL mixed_sed: got %h want 20008", sed); end
    tick(); tick();
    // Metrics hold in IDLE.
    checks++; if (sed !== 19'h20008) begin errors++; $display("FAIL mixed_hold: got %h want 20008", sed); end
  endtask

  task automatic test_gaps_ignored_start();
    int done_seen;
    done_seen = 0;
    do_start();
    drive_sample(16'h0001, 16'h0001, 1'b0, 17'h00001);   // ED 1
    drive_sample(16'h0002, 16'h0000, 1'b0, 17'h00004);   // ED 2
    for (int i = 0; i < 3; i++) begin
      start = (i == 1) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    checks++; if (sed !== 19'h00003) begin errors++; $display("FAIL gaps_start_ignored: got %h want 00003", sed); end
    checks++; if ({in_ready, busy} !== 2'b11) begin errors++; $display("FAIL gaps_still_run: got rdy/busy %b%b want 11", in_ready, busy); end
    drive_sample(16'h0010, 16'h0020, 1'b0, 17'h00030);   // exact
    tick(); tick(); tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL gaps_three_not_final: got rdy %b want 1", in_ready); end
    drive_sample(16'h0000, 16'h0000, 1'b1, 17'h00000);   // ED 1
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    checks++; if (done_seen !== 1) begin errors++; $display("FAIL gaps_done_once: got %0d pulses want 1", done_seen); end
    checks++; if ({err_count, max_ed, sed} !== {3'd3, 17'h00002, 19'h00004}) begin errors++; $display("FAIL gaps_metrics: got %h/%h/%h want 3/00002/00004", err_count, max_ed, sed); end
  endtask

  task automatic test_reset_mid_window();
    do_start();
    drive_sample(16'hFFFF, 16'hFFFF, 1'b1, 17'h00000);
    drive_sample(16'h0000, 16'h0000, 1'b0, 17'h00009);
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({in_ready, busy, done} !== 3'b000) begin errors++; $display("FAIL midrst_ctrl: got rdy/busy/done %b%b%b want 000", in_ready, busy, done); end
    checks++; if ({err_count, max_ed, sed} !== 39'h0) begin errors++; $display("FAIL midrst_metrics: got %h/%h/%h want 0", err_count, max_ed, sed); end
    tick();
    rst = 1'b0;
    tick();
    do_start();
    drive_sample(16'h0004, 16'h0004, 1'b0, 17'h00000);   // ED 8
    drive_sample(16'h0001, 16'h0000, 1'b0, 17'h00001);   // exact
    drive_sample(16'h0000, 16'h0000, 1'b0, 17'h00003);   // ED 3
    drive_sample(16'h0005, 16'h0005, 1'b1, 17'h0000B);   // exact
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b want 1", done); end
    checks++; if ({err_count, max_ed, sed} !== {3'd2, 17'h00008, 19'h0000B}) begin errors++; $display("FAIL midrst_new_window: got %h/%h/%h want 2/00008/0000b", err_count, max_ed, sed); end
  endtask

  task automatic test_back_to_back();
    do_start();
    drive_sample(16'h0000, 16'h0000, 1'b0, 17'h00010);   // ED 16
    drive_sample(16'h0000, 16'h0000, 1'b0, 17'h00010);
    drive_sample(16'h0000, 16'h0000, 1'b0, 17'h00010);
    drive_sample(16'h0000, 16'h0000, 1'b0, 17'h00010);
    tick();
    checks++; if ({done, sed} !== {1'b1, 19'h00040}) begin errors++; $display("FAIL b2b_first: got done/sed %b/%h want 1/00040", done, sed); end
    do_start();   // Start in the Done cycle
    checks++; if ({in_ready, busy, done} !== 3'b110) begin errors++; $display("FAIL b2b_restart_ctrl: got rdy/busy/done %b%b%b want 110", in_ready, busy, done); end
    checks++; if ({err_count, max_ed, sed} !== 39'h0) begin errors++; $display("FAIL b2b_restart_clear: got %h/%h/%h want 0", err_count, max_ed, sed); end
    drive_sample(16'h7FFF, 16'h0001, 1'b0, 17'h08001);   // ED 1
    drive_sample(16'h0003, 16'h0003, 1'b0, 17'h00006);   // exact
    drive_sample(16'h0000, 16'h0000, 1'b0, 17'h00020);   // ED 32
    drive_sample(16'hFFFF, 16'h0000, 1'b1, 17'h0FFFF);   // ED 1
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b want 1", done); end
    checks++; if ({err_count, max_ed, sed} !== {3'd3, 17'h00020, 19'h00022}) begin errors++; $display("FAIL b2b_second_metrics: got %h/%h/%h want 3/00020/00022", err_count, max_ed, sed); end
  endtask

  initial begin
    test_reset();
    test_exact_window();
    test_mixed_errors();
    test_gaps_ignored_start();
    test_reset_mid_window();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
